// File: rtl/sd_host_regfile.sv
// sd_host_regfile: SD host register file with req/ack CPU port, byte enables, RO masking, hw update and W1C interrupt status.
// Optional feature macro SD_REGS_IRQ_EN builds the irq output; otherwise irq is tied low.
module sd_host_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS = 28,
  parameter logic [NUM_REGS-1:0] RO_MASK = 28'h20F_03F0,
  parameter int INT_STAT_ADDR = 12,
  parameter int INT_ENA_ADDR = 13,
  parameter int INT_SIG_ADDR = 14,
  localparam int BE_W = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req,
  input  logic                           rw,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic [BE_W-1:0]                be,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           ack,
  output logic                           err,
  input  logic [NUM_REGS-1:0]            hw_we,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_data,
  input  logic [DATA_WIDTH-1:0]          int_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic                           irq
);
  typedef enum logic {IDLE, ACK} state_e;
  state_e state_q, state_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d, hw_arr;
  logic [DATA_WIDTH-1:0] wmask, data_out_q, data_out_d;
  logic ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic start, in_range, cpu_wr, stat_hit;
  assign hw_arr = hw_data;
  assign start = state_q == IDLE && req;
  assign in_range = 32'(addr) < NUM_REGS;
  assign cpu_wr = start && !rw && in_range;
  assign stat_hit = cpu_wr && 32'(addr) == INT_STAT_ADDR;
  always_comb begin
    wmask = '0;
    for (int k = 0; k < BE_W; k++) wmask[k*8 +: 8] = {8{be[k]}};
  end
  // hw first, then CPU merges its enabled lanes over it (CPU wins on RW, RO keeps hw)
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hw_we[i]) regs_d[i] = hw_arr[i];
      if (cpu_wr && 32'(addr) == i && !RO_MASK[i]) regs_d[i] = (regs_d[i] & ~wmask) | (data_in & wmask);
    end
    regs_d[INT_STAT_ADDR] = (regs_q[INT_STAT_ADDR] & ~(stat_hit ? data_in & wmask : '0))
                          | (int_set & regs_q[INT_ENA_ADDR]);
  end
  always_comb begin
    state_d = state_q;
    ack_d = ack_q;
    err_d = err_q;
    data_out_d = data_out_q;
    if (start) begin
      state_d = ACK;
      ack_d = 1'b1;
      err_d = !in_range;
      data_out_d = (rw && in_range) ? regs_q[addr] : '0;
    end else if (state_q == ACK && !req) begin
      state_d = IDLE;
      ack_d = 1'b0;
    end
  end
`ifdef SD_REGS_IRQ_EN
  assign irq_d = |(regs_q[INT_STAT_ADDR] & regs_q[INT_SIG_ADDR]);
`else
  assign irq_d = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      regs_q <= '0;
      data_out_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q <= regs_d;
      data_out_q <= data_out_d;
      ack_q <= ack_d;
      err_q <= err_d;
      irq_q <= irq_d;
    end
  end
  assign data_out = data_out_q;
  assign ack = ack_q;
  assign err = err_q;
  assign irq = irq_q;
  assign regs_flat = regs_q;
endmodule

// File: tb/tb_sd_host_regfile.sv
// tb_sd_host_regfile: randomized scoreboard bench for sd_host_regfile against a behavioural register model.
module tb_sd_host_regfile;
  localparam int N = 28;
  localparam int STAT = 12, ENA = 13, SIG = 14;
  localparam logic [N-1:0] RO = 28'h20F_03F0;
`ifdef SD_REGS_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, rw = 1'b0;
  logic [4:0] addr = '0;
  logic [31:0] data_in = '0, int_set = '0, data_out;
  logic [3:0] be = '0;
  logic ack, err, irq;
  logic [N-1:0] hw_we = '0;
  logic [N*32-1:0] hw_data = '0, regs_flat;
  sd_host_regfile dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .data_in(data_in), .be(be),
    .data_out(data_out), .ack(ack), .err(err), .hw_we(hw_we), .hw_data(hw_data),
    .int_set(int_set), .regs_flat(regs_flat), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] d; logic e;} rsp_t;
  rsp_t exp_q[$];
  logic [31:0] m [N];
  bit busy = 0;
  logic ack_prev = 1'b0;
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask
  // response monitor: every new ack consumes the oldest expected response
  always @(negedge clk) begin
    if (ack === 1'b1 && ack_prev !== 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rdata", data_out, e.d);
        chk("err", {31'd0, err}, {31'd0, e.e});
      end
    end
    ack_prev = ack;
  end
  // one clock: update the model from the current inputs, then check handshake, irq and all registers
  task automatic cycle();
    logic [31:0] nm [N];
    bit irq_n, wr;
    int bad;
    irq_n = IRQ_EN && ((m[STAT] & m[SIG]) != 0);
    if (reset) begin
      foreach (m[i]) m[i] = '0;
      busy = 0;
      irq_n = 0;
    end else begin
      wr = req && !busy && !rw && addr < N;
      if (req && !busy) begin
        exp_q.push_back('{d: (rw && addr < N) ? m[addr] : 32'd0, e: addr >= N});
        busy = 1;
      end else if (busy && !req) busy = 0;
      foreach (m[i]) begin
        nm[i] = m[i];
        if (i == STAT) begin
          for (int k = 0; k < 4; k++)
            if (wr && addr == i && be[k]) nm[i][k*8 +: 8] = m[i][k*8 +: 8] & ~data_in[k*8 +: 8];
          nm[i] = nm[i] | (int_set & m[ENA]);
        end else begin
          if (hw_we[i]) nm[i] = hw_data[i*32 +: 32];
          for (int k = 0; k < 4; k++)
            if (wr && addr == i && !RO[i] && be[k]) nm[i][k*8 +: 8] = data_in[k*8 +: 8];
        end
      end
      foreach (m[i]) m[i] = nm[i];
    end
    @(posedge clk);
    #1;
    chk("ack", {31'd0, ack}, {31'd0, busy});
    chk("irq", {31'd0, irq}, {31'd0, irq_n});
    bad = -1;
    foreach (m[i]) if (bad < 0 && regs_flat[i*32 +: 32] !== m[i]) bad = i;
    chk("regs", bad < 0 ? 32'd0 : regs_flat[bad*32 +: 32], bad < 0 ? 32'd0 : m[bad]);
    @(negedge clk);
  endtask
  task automatic access(input logic r, input logic [4:0] a, input logic [31:0] d, input logic [3:0] b,
                        input logic [N-1:0] hwe, input logic [N*32-1:0] hwd, input logic [31:0] is);
    req = 1'b1; rw = r; addr = a; data_in = d; be = b;
    hw_we = hwe; hw_data = hwd; int_set = is;
    cycle();
    hw_we = '0; int_set = '0;
    for (int n = 0; n < 5 && ack !== 1'b1; n++) cycle();
    if (ack !== 1'b1) chk("ack_timeout", 32'd0, 32'd1);
    req = 1'b0;
    cycle();
  endtask
  task automatic hw_pulse(input int i, input logic [31:0] d, input logic [31:0] is);
    hw_we = '0;
    if (i >= 0) begin hw_we[i] = 1'b1; hw_data[i*32 +: 32] = d; end
    int_set = is;
    cycle();
    hw_we = '0; int_set = '0;
  endtask
  function automatic logic [N*32-1:0] hw_one(input int i, input logic [31:0] d);
    logic [N*32-1:0] v;
    v = '0;
    v[i*32 +: 32] = d;
    return v;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    access(1, 3, 0, 0, '0, '0, 0);
    access(0, 1, 32'hAABBCCDD, 4'b0101, '0, '0, 0);
    access(1, 1, 0, 0, '0, '0, 0);
    access(0, 4, 32'hFFFFFFFF, 4'hF, '0, '0, 0);
    access(1, 4, 0, 0, '0, '0, 0);
    hw_pulse(4, 32'h12345678, 0);
    access(1, 4, 0, 0, '0, '0, 0);
    access(1, 30, 0, 0, '0, '0, 0);
    access(0, 30, 32'hDEADBEEF, 4'hF, '0, '0, 0);
    access(0, 2, 32'h11223344, 4'b0011, N'(1) << 2, hw_one(2, 32'hCAFEF00D), 0);
    access(0, 5, 32'h55555555, 4'hF, N'(1) << 5, hw_one(5, 32'h0BADC0DE), 0);
    access(1, 2, 0, 0, '0, '0, 0);
    access(0, ENA, 32'h1, 4'hF, '0, '0, 0);
    access(0, SIG, 32'h1, 4'hF, '0, '0, 0);
    hw_pulse(-1, 0, 32'h3);
    cycle();
    access(1, STAT, 0, 0, '0, '0, 0);
    access(0, STAT, 32'h1, 4'hF, '0, '0, 32'h1);
    access(1, STAT, 0, 0, '0, '0, 0);
    access(0, STAT, 32'h1, 4'hF, '0, '0, 0);
    cycle();
    access(1, STAT, 0, 0, '0, '0, 0);
    req = 1'b1; rw = 1'b1; addr = 5'd1;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    req = 1'b0;
    cycle();
    for (int t = 0; t < 300; t++) begin
      logic [N-1:0] hwe;
      logic [N*32-1:0] hwd;
      int r;
      hwe = '0;
      hwd = '0;
      r = $urandom_range(0, 3 * N);
      if (r < N) begin hwe[r] = 1'b1; hwd[r*32 +: 32] = $urandom; end
      access($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 5'($urandom_range(STAT, SIG)) : 5'($urandom),
             $urandom, 4'($urandom), hwe, hwd, ($urandom_range(0, 2) == 0) ? $urandom : 32'd0);
      if ($urandom_range(0, 2) == 0) hw_pulse($urandom_range(0, N - 1), $urandom, $urandom);
    end
    cycle();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
